// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL
  } icache_state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  function automatic int unsigned offset_bits(input int unsigned words);
    return $clog2(words) + 2;
  endfunction

  function automatic int unsigned index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned words, input int unsigned sets);
    return 32 - offset_bits(words) - index_bits(sets);
  endfunction

  // Width of a selector over n items; never zero so degenerate configs still elaborate.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface icache_assoc_if #(
  parameter int unsigned WORDS_PER_LINE = 4
);
  logic [31:0]                   pc_in;
  logic                          fetch_en;
  logic                          flush;
  logic [31:0]                   instr_out;
  logic                          stall_out;
  logic                          mem_req;
  logic [31:0]                   mem_addr;
  logic                          mem_ack;
  logic [32*WORDS_PER_LINE-1:0]  mem_line;

  modport slave (
    input  pc_in, fetch_en, flush, mem_ack, mem_line,
    output instr_out, stall_out, mem_req, mem_addr
  );

  modport master (
    output pc_in, fetch_en, flush, mem_ack, mem_line,
    input  instr_out, stall_out, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_way.sv
// One cache way: valid/tag/data per set, combinational read, single write port.
module icache_way #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TAG_W    = 24,
  parameter int unsigned LINE_W   = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  // Clear has priority so a flush coinciding with a fill leaves the way empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational lookup, refill FSM, round-robin replacement, flush.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int unsigned NUM_WAYS       = 2,
  parameter int unsigned NUM_SETS       = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  icache_assoc_if.slave   bus
);

  localparam int unsigned OFF_W      = offset_bits(WORDS_PER_LINE);
  localparam int unsigned IDX_BITS   = index_bits(NUM_SETS);
  localparam int unsigned IDX_W      = sel_width(NUM_SETS);
  localparam int unsigned TAG_W      = tag_bits(WORDS_PER_LINE, NUM_SETS);
  localparam int unsigned WSEL_W     = sel_width(WORDS_PER_LINE);
  localparam int unsigned WAY_W      = sel_width(NUM_WAYS);
  localparam int unsigned LINE_W     = 32 * WORDS_PER_LINE;
  localparam int unsigned LINE_BYTES = 4 * WORDS_PER_LINE;

  icache_state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_c;
  logic [TAG_W-1:0]  tag_c;
  logic [WSEL_W-1:0] wsel_c;

  logic [NUM_WAYS-1:0] way_valid;
  logic [TAG_W-1:0]    way_tag  [NUM_WAYS];
  logic [LINE_W-1:0]   way_line [NUM_WAYS];

  logic              hit_c;
  logic [LINE_W-1:0] hit_line_c;
  logic [WAY_W-1:0]  victim_c;
  logic              full_c;
  logic [WAY_W-1:0]  rr_c;

  logic              start_miss_c;
  logic              fill_we_c;
  logic              stall_c;
  logic [31:0]       instr_c;

  logic [31:0]       mem_addr_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [WAY_W-1:0]  victim_q;
  logic              victim_full_q;
  logic [LINE_W-1:0] line_q;
  logic              kill_q;

  assign idx_c  = IDX_W'((bus.pc_in >> OFF_W) & (NUM_SETS - 1));
  assign tag_c  = TAG_W'(bus.pc_in >> (OFF_W + IDX_BITS));
  assign wsel_c = WSEL_W'((bus.pc_in >> 2) & (WORDS_PER_LINE - 1));

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    icache_way #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W),
      .TAG_W    (TAG_W),
      .LINE_W   (LINE_W)
    ) u_way (
      .clock    (clock),
      .reset    (reset),
      .clear    (bus.flush),
      .rd_index (idx_c),
      .rd_valid (way_valid[g]),
      .rd_tag   (way_tag[g]),
      .rd_line  (way_line[g]),
      .wr_en    (fill_we_c && (victim_q == WAY_W'(g))),
      .wr_index (fill_idx_q),
      .wr_tag   (fill_tag_q),
      .wr_line  (line_q)
    );
  end

  // Tag compare and one-hot line select.
  always_comb begin
    hit_c      = 1'b0;
    hit_line_c = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == tag_c)) begin
        hit_c      = 1'b1;
        hit_line_c = hit_line_c | way_line[w];
      end
    end
  end

  // Victim: lowest-index invalid way, else the set's round-robin pointer.
  always_comb begin
    victim_c = rr_c;
    full_c   = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_c = WAY_W'(w);
        full_c   = 1'b0;
      end
    end
  end

  if (NUM_WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] rr_q [NUM_SETS];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      end else if (fill_we_c && victim_full_q) begin
        rr_q[fill_idx_q] <= WAY_W'(victim_q + 1'b1);
      end
    end

    assign rr_c = rr_q[idx_c];
  end else begin : g_no_rr
    assign rr_c = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    stall_c      = 1'b0;
    instr_c      = NOP_INSTR;
    start_miss_c = 1'b0;
    fill_we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fetch_en) begin
          if (hit_c) begin
            instr_c = hit_line_c[{wsel_c, 5'd0} +: 32];
          end else begin
            stall_c      = 1'b1;
            start_miss_c = 1'b1;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        stall_c = 1'b1;
        if (bus.mem_ack) state_d = FILL;
      end
      FILL: begin
        stall_c   = 1'b1;
        fill_we_c = !bus.flush && !kill_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss bookkeeping; a flush seen while refilling suppresses the install.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_q    <= '0;
      fill_tag_q    <= '0;
      fill_idx_q    <= '0;
      victim_q      <= '0;
      victim_full_q <= 1'b0;
      line_q        <= '0;
      kill_q        <= 1'b0;
    end else begin
      if (start_miss_c) begin
        mem_addr_q    <= bus.pc_in & ~32'(LINE_BYTES - 1);
        fill_tag_q    <= tag_c;
        fill_idx_q    <= idx_c;
        victim_q      <= victim_c;
        victim_full_q <= full_c;
        kill_q        <= 1'b0;
      end
      if (state_q == REFILL) begin
        if (bus.flush) kill_q <= 1'b1;
        if (bus.mem_ack) line_q <= bus.mem_line;
      end
    end
  end

  assign bus.instr_out = instr_c;
  assign bus.stall_out = stall_c;
  assign bus.mem_req   = (state_q == REFILL);
  assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed and randomized fetch sequences checked against an array-based cache model.
module tb_icache_assoc;
  import icache_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_assoc_if #(.WORDS_PER_LINE(4)) bus();

  icache_assoc #(
    .NUM_WAYS(2), .NUM_SETS(16), .WORDS_PER_LINE(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 16 sets x 2 ways of {valid, tag}, plus a per-set round-robin pointer.
  bit          mv  [16][2];
  logic [23:0] mt  [16][2];
  int          mrr [16];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] b;
    b = a & 32'hFFFF_FFFC;
    return b * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = a & 32'hFFFF_FFF0;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = word_of(base + 32'(4 * w));
    return l;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s;
    s = int'((a >> 4) & 32'hF);
    for (int w = 0; w < 2; w++)
      if (mv[s][w] && mt[s][w] == a[31:8]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_install(input logic [31:0] a);
    int s;
    int v;
    s = int'((a >> 4) & 32'hF);
    v = -1;
    for (int w = 0; w < 2; w++) if (!mv[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = mrr[s];
      mrr[s] = (mrr[s] + 1) % 2;
    end
    mv[s][v] = 1'b1;
    mt[s][v] = a[31:8];
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 16; s++) for (int w = 0; w < 2; w++) mv[s][w] = 1'b0;
  endfunction

  function automatic void m_reset();
    m_clear();
    for (int s = 0; s < 16; s++) mrr[s] = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch; on a miss, serve the refill after lat REFILL cycles, optionally
  // flushing in REFILL cycle flush_cyc or redirecting pc_in to baddr.
  task automatic fetch(input logic [31:0] addr, input int lat, input int flush_cyc,
                       input bit branch, input logic [31:0] baddr);
    bit exp_hit;
    bit killed;
    int scnt;
    bus.pc_in    = addr;
    bus.fetch_en = 1'b1;
    @(negedge clock);
    exp_hit = m_hit(addr);
    chk("lookup_stall", 32'(bus.stall_out), 32'(!exp_hit));
    chk("lookup_req", 32'(bus.mem_req), 32'd0);
    if (exp_hit) begin
      chk("hit_instr", bus.instr_out, word_of(addr));
      @(posedge clock); #1;
      return;
    end
    chk("miss_instr", bus.instr_out, NOP_INSTR_DEF);
    scnt   = 1;
    killed = 1'b0;
    @(posedge clock); #1;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clock);
      chk("refill_req", 32'(bus.mem_req), 32'd1);
      chk("refill_addr", bus.mem_addr, addr & 32'hFFFF_FFF0);
      if (bus.stall_out) scnt++;
      if (branch && n == 1) bus.pc_in = baddr;
      if (n == flush_cyc) begin
        bus.flush = 1'b1;
        killed    = 1'b1;
      end
      if (n == lat) begin
        bus.mem_ack  = 1'b1;
        bus.mem_line = line_of(addr);
      end
      @(posedge clock); #1;
      bus.flush   = 1'b0;
      bus.mem_ack = 1'b0;
    end
    @(negedge clock);
    chk("fill_stall", 32'(bus.stall_out), 32'd1);
    chk("fill_req", 32'(bus.mem_req), 32'd0);
    if (bus.stall_out) scnt++;
    if (killed) begin
      m_clear();
      bus.fetch_en = 1'b0;
    end else begin
      m_install(addr);
    end
    @(posedge clock); #1;
    if (killed) begin
      @(negedge clock);
      chk("killed_stall", 32'(bus.stall_out), 32'd0);
      chk("killed_req", 32'(bus.mem_req), 32'd0);
      @(posedge clock); #1;
      return;
    end
    if (branch) return;
    @(negedge clock);
    chk("stall_cycles", 32'(scnt), 32'(lat + 2));
    chk("post_fill_stall", 32'(bus.stall_out), 32'd0);
    chk("post_fill_instr", bus.instr_out, word_of(addr));
    @(posedge clock); #1;
  endtask

  // Flush pulse in IDLE; fetch only if the address hits so no refill starts.
  task automatic flush_idle(input logic [31:0] addr);
    bit h;
    h = m_hit(addr);
    bus.pc_in    = addr;
    bus.fetch_en = h;
    bus.flush    = 1'b1;
    @(negedge clock);
    chk("flush_stall", 32'(bus.stall_out), 32'd0);
    chk("flush_instr", bus.instr_out, h ? word_of(addr) : NOP_INSTR_DEF);
    @(posedge clock); #1;
    bus.flush    = 1'b0;
    bus.fetch_en = 1'b0;
    m_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int lat;
    bus.pc_in    = '0;
    bus.fetch_en = 1'b0;
    bus.flush    = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_line = '0;
    m_reset();

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_stall", 32'(bus.stall_out), 32'd0);
    chk("reset_instr", bus.instr_out, NOP_INSTR_DEF);
    chk("reset_req", 32'(bus.mem_req), 32'd0);
    chk("reset_addr", bus.mem_addr, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Cold miss, then the rest of the line in consecutive cycles.
    fetch(32'h100, 3, 0, 1'b0, 32'h0);
    fetch(32'h104, 3, 0, 1'b0, 32'h0);
    fetch(32'h108, 3, 0, 1'b0, 32'h0);
    fetch(32'h10C, 3, 0, 1'b0, 32'h0);

    // Flush in IDLE: same-cycle hit, then a miss.
    flush_idle(32'h100);
    fetch(32'h100, 2, 0, 1'b0, 32'h0);

    // Replacement within set 0.
    flush_idle(32'h0);
    fetch(32'h000, 1, 0, 1'b0, 32'h0);
    fetch(32'h100, 2, 0, 1'b0, 32'h0);
    fetch(32'h200, 3, 0, 1'b0, 32'h0);
    fetch(32'h104, 2, 0, 1'b0, 32'h0);
    fetch(32'h008, 2, 0, 1'b0, 32'h0);
    fetch(32'h204, 2, 0, 1'b0, 32'h0);

    // Branch during refill.
    flush_idle(32'h0);
    fetch(32'h100, 3, 0, 1'b1, 32'h400);
    fetch(32'h400, 2, 0, 1'b0, 32'h0);
    fetch(32'h10C, 2, 0, 1'b0, 32'h0);

    // Flush during refill: handshake completes, nothing installed.
    fetch(32'h500, 3, 2, 1'b0, 32'h0);
    fetch(32'h500, 2, 0, 1'b0, 32'h0);
    fetch(32'h400, 2, 0, 1'b0, 32'h0);

    // Async reset in REFILL, then a stale ack.
    bus.pc_in    = 32'h300;
    bus.fetch_en = 1'b1;
    @(negedge clock);
    chk("rst_miss_stall", 32'(bus.stall_out), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_refill_req", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req", 32'(bus.mem_req), 32'd0);
    bus.fetch_en = 1'b0;
    m_reset();
    @(posedge clock); #1;
    reset        = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_line = line_of(32'h300);
    @(negedge clock);
    chk("stale_ack_stall", 32'(bus.stall_out), 32'd0);
    chk("stale_ack_instr", bus.instr_out, NOP_INSTR_DEF);
    chk("stale_ack_req", 32'(bus.mem_req), 32'd0);
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    @(negedge clock);
    chk("stale_ack_idle", 32'(bus.mem_req), 32'd0);
    @(posedge clock); #1;
    fetch(32'h300, 2, 0, 1'b0, 32'h0);

    // Randomized fetches over a small address pool that forces set conflicts.
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 2)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0)
        flush_idle(a);
      else if ($urandom_range(0, 5) == 0)
        fetch(a, lat, int'($urandom_range(1, lat)), 1'b0, 32'h0);
      else
        fetch(a, lat, 0, 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
